// File: rtl/cache_fill_ctrl_if.sv
// Bundle of signals between the fill controller, the two cache miss ports and the
// shared main-memory read port.
interface cache_fill_ctrl_if;
    // Memory read port has no ready: memory accepts one request every cycle that
    // mem_enable is high and returns words in request order, one per mem_data_valid.
    logic        icache_miss;
    logic [15:0] icache_miss_addr;
    logic        dcache_miss;
    logic [15:0] dcache_miss_addr;
    logic        mem_data_valid;
    logic [15:0] mem_data_in;
    logic        mem_enable;
    logic [15:0] mem_addr;
    logic        fill_target;
    logic        fill_word_en;
    logic [2:0]  fill_word_offset;
    logic [15:0] fill_data;
    logic [15:0] fill_block_addr;
    logic        fill_tag_write;
    logic        icache_stall;
    logic        dcache_stall;
    logic        busy;

    modport master (
        input  icache_miss, icache_miss_addr, dcache_miss, dcache_miss_addr,
        input  mem_data_valid, mem_data_in,
        output mem_enable, mem_addr, fill_target, fill_word_en, fill_word_offset,
        output fill_data, fill_block_addr, fill_tag_write, icache_stall, dcache_stall, busy
    );

    modport slave (
        output icache_miss, icache_miss_addr, dcache_miss, dcache_miss_addr,
        output mem_data_valid, mem_data_in,
        input  mem_enable, mem_addr, fill_target, fill_word_en, fill_word_offset,
        input  fill_data, fill_block_addr, fill_tag_write, icache_stall, dcache_stall, busy
    );
endinterface

// File: rtl/cache_fill_ctrl.sv
// Miss-handling controller: arbitrates I/D read misses, streams one 8-word block
// from memory into the winning cache, then pulses its tag/valid write.
module cache_fill_ctrl #(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int MEM_LATENCY     = 4
) (
    input  logic              clk,
    input  logic              rst,
    cache_fill_ctrl_if.master io_bus,
    output logic [1:0]        o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] LP_WORDS = 4'(WORDS_PER_BLOCK);
    localparam logic [3:0] LP_LAST  = 4'(WORDS_PER_BLOCK - 1);

    // Offset and counter widths are fixed for 16B blocks of 16-bit words.
    if (WORDS_PER_BLOCK != 8 || MEM_LATENCY < 1) begin : g_param_check
        $error("cache_fill_ctrl: WORDS_PER_BLOCK must be 8 and MEM_LATENCY >= 1");
    end

    state_t      r_state;
    logic [3:0]  r_issue_cnt;
    logic [3:0]  r_recv_cnt;
    logic        r_last_served;
    logic [15:0] r_base;
    logic        r_target;
    logic        r_mem_enable;
    logic [15:0] r_mem_addr;
    logic        r_tag_write;
    logic        r_busy;

    logic        w_any_miss;
    logic        w_pick_d;
    logic [15:0] w_win_base;
    logic        w_recv;

    // On a tie the cache that was not served last wins, so neither can starve.
    always_comb begin
        w_any_miss = io_bus.icache_miss | io_bus.dcache_miss;
        w_pick_d   = io_bus.dcache_miss & (~io_bus.icache_miss | ~r_last_served);
        w_win_base = (w_pick_d ? io_bus.dcache_miss_addr : io_bus.icache_miss_addr) & 16'hFFF0;
        w_recv     = (r_state == S_FILL) & io_bus.mem_data_valid & (r_recv_cnt < LP_WORDS);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_issue_cnt   <= 4'd0;
            r_recv_cnt    <= 4'd0;
            r_last_served <= 1'b1;
            r_base        <= 16'h0000;
            r_target      <= 1'b0;
            r_mem_enable  <= 1'b0;
            r_mem_addr    <= 16'h0000;
            r_tag_write   <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tag_write  <= 1'b0;
                    r_mem_enable <= 1'b0;
                    if (w_any_miss) begin
                        r_base        <= w_win_base;
                        r_target      <= w_pick_d;
                        r_last_served <= w_pick_d;
                        r_mem_enable  <= 1'b1;
                        r_mem_addr    <= w_win_base;
                        r_issue_cnt   <= 4'd1;
                        r_recv_cnt    <= 4'd0;
                        r_busy        <= 1'b1;
                        r_state       <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (r_issue_cnt < LP_WORDS) begin
                        r_mem_enable <= 1'b1;
                        r_mem_addr   <= r_base + {11'd0, r_issue_cnt, 1'b0};
                        r_issue_cnt  <= r_issue_cnt + 4'd1;
                    end else begin
                        r_mem_enable <= 1'b0;
                    end
                    if (w_recv) begin
                        r_recv_cnt <= r_recv_cnt + 4'd1;
                        if (r_recv_cnt == LP_LAST) begin
                            r_tag_write <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_tag_write  <= 1'b0;
                    r_mem_enable <= 1'b0;
                    r_issue_cnt  <= 4'd0;
                    r_recv_cnt   <= 4'd0;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign io_bus.mem_enable       = r_mem_enable;
    assign io_bus.mem_addr         = r_mem_addr;
    assign io_bus.fill_target      = r_target;
    assign io_bus.fill_block_addr  = r_base;
    assign io_bus.fill_tag_write   = r_tag_write;
    assign io_bus.busy             = r_busy;
    assign io_bus.fill_word_en     = w_recv;
    assign io_bus.fill_word_offset = r_recv_cnt[2:0];
    assign io_bus.fill_data        = io_bus.mem_data_in;
    assign io_bus.icache_stall     = io_bus.icache_miss | (r_busy & ~r_target);
    assign io_bus.dcache_stall     = io_bus.dcache_miss | (r_busy & r_target);
    assign o_dbg_state             = r_state;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Bench for cache_fill_ctrl: fixed-latency memory model, scoreboard of expected
// fill words, and one task per scenario.
module tb_cache_fill_ctrl;
  localparam int L = 4;
  localparam int W = 36;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] dbg_state;
  always #5 clk = ~clk;

  cache_fill_ctrl_if bus();

  cache_fill_ctrl #(.WORDS_PER_BLOCK(8), .MEM_LATENCY(L)) dut (
    .clk(clk),
    .rst(rst),
    .io_bus(bus),
    .o_dbg_state(dbg_state)
  );

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  // memory model: in-order, fixed latency, optional 2-cycle gaps, optional stray valids
  logic [15:0] req_addr_q[$];
  int req_due_q[$];
  bit gap_mode = 1'b0;
  bit stray_mode = 1'b0;
  int last_ret = -100;

  always @(negedge clk) begin
    if (bus.mem_enable === 1'b1) begin
      req_addr_q.push_back(bus.mem_addr);
      req_due_q.push_back(cyc + L);
    end
    bus.mem_data_valid = 1'b0;
    bus.mem_data_in = 16'h0000;
    if (req_due_q.size() > 0 && req_due_q[0] <= cyc && (!gap_mode || cyc - last_ret >= 3)) begin
      bus.mem_data_valid = 1'b1;
      bus.mem_data_in = mem_word(req_addr_q.pop_front());
      void'(req_due_q.pop_front());
      last_ret = cyc;
    end else if (stray_mode) begin
      bus.mem_data_valid = 1'b1;
      bus.mem_data_in = 16'hDEAD;
    end
  end

  // scoreboard and observation log
  logic [W-1:0] exp_q[$];
  logic [W-1:0] sb_exp, sb_got;
  int word_cnt = 0, tag_cnt = 0, last_word_cyc = -1, tag_cyc = -1, last_busy_cyc = -1;
  logic [15:0] tag_addr;
  logic tag_tgt;
  logic served_q[$];
  int en_cyc_q[$];
  logic [15:0] en_addr_q[$];
  int snap_a_cyc = -1, snap_b_cyc = -1;
  logic [3:0] snap_a, snap_b;

  task automatic monitor();
    if (bus.fill_word_en === 1'b1) begin
      word_cnt++;
      last_word_cyc = cyc;
      sb_got = {bus.fill_target, bus.fill_word_offset, bus.fill_data, bus.fill_block_addr};
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_word: cycle %0d got {tgt,off,data,blk}=%h, required no word", cyc, sb_got);
      end else begin
        sb_exp = exp_q.pop_front();
        if (sb_got !== sb_exp) begin
          n_fail++;
          $display("FAIL fill_word: cycle %0d got {tgt,off,data,blk}=%h, required %h", cyc, sb_got, sb_exp);
        end
      end
    end
    if (bus.fill_tag_write === 1'b1) begin
      tag_cnt++;
      tag_cyc = cyc;
      tag_addr = bus.fill_block_addr;
      tag_tgt = bus.fill_target;
      served_q.push_back(bus.fill_target);
    end
    if (bus.mem_enable === 1'b1) begin
      en_cyc_q.push_back(cyc);
      en_addr_q.push_back(bus.mem_addr);
    end
    if (bus.busy === 1'b1) last_busy_cyc = cyc;
    if (cyc == snap_a_cyc) snap_a = {bus.icache_stall, bus.dcache_stall, bus.busy, bus.fill_target};
    if (cyc == snap_b_cyc) snap_b = {bus.icache_stall, bus.dcache_stall, bus.busy, bus.fill_target};
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
    monitor();
    #1;
  endtask

  task automatic clear_log();
    word_cnt = 0; tag_cnt = 0; last_word_cyc = -1; tag_cyc = -1; last_busy_cyc = -1;
    served_q.delete(); en_cyc_q.delete(); en_addr_q.delete();
    snap_a_cyc = -1; snap_b_cyc = -1; snap_a = 4'h0; snap_b = 4'h0;
  endtask

  task automatic push_block(input logic tgt, input logic [15:0] base);
    for (int i = 0; i < 8; i++) begin
      logic [15:0] a;
      a = base + 16'(2 * i);
      exp_q.push_back({tgt, 3'(i), mem_word(a), base});
    end
  endtask

  // cache side: drop a miss during the cycle its tag write is seen
  task automatic run_until_idle(input int budget, input bit chk_dstall, output int dstall_bad);
    int n;
    n = 0;
    dstall_bad = 0;
    while ((bus.icache_miss || bus.dcache_miss || bus.busy === 1'b1) && n < budget) begin
      tick();
      n++;
      if (chk_dstall && bus.dcache_miss && bus.dcache_stall !== 1'b1) dstall_bad++;
      if (bus.fill_tag_write === 1'b1) begin
        if (bus.fill_target) bus.dcache_miss = 1'b0;
        else bus.icache_miss = 1'b0;
      end
    end
    n_tests++;
    if (n >= budget) begin
      n_fail++;
      $display("FAIL run_timeout: fill not finished after %0d cycles, required completion", n);
      bus.icache_miss = 1'b0;
      bus.dcache_miss = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_tests++;
    if ({bus.busy, bus.mem_enable, bus.fill_word_en, bus.fill_tag_write, bus.icache_stall,
         bus.dcache_stall, bus.fill_target} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b, required 0000000", {bus.busy, bus.mem_enable,
               bus.fill_word_en, bus.fill_tag_write, bus.icache_stall, bus.dcache_stall, bus.fill_target});
    end
    n_tests++;
    if (bus.mem_addr !== 16'h0 || bus.fill_block_addr !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_addr: got mem_addr %h blk %h, required 0000 0000", bus.mem_addr, bus.fill_block_addr);
    end
    n_tests++;
    if (bus.fill_word_offset !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_offset: got %0d, required 0", bus.fill_word_offset);
    end
    n_tests++;
    if (dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %0d, required 0", dbg_state);
    end
    rst = 1'b0;
    repeat (2) tick();
    n_tests++;
    if (bus.busy !== 1'b0 || bus.mem_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_miss: got busy %b mem_enable %b, required 0 0", bus.busy, bus.mem_enable);
    end
  endtask

  task automatic test_single_imiss();
    int t0, bad;
    clear_log();
    bus.icache_miss_addr = 16'h1236;
    bus.icache_miss = 1'b1;
    t0 = cyc;
    push_block(1'b0, 16'h1230);
    #1;
    n_tests++;
    if (bus.icache_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL imiss_stall: got %b, required 1", bus.icache_stall);
    end
    run_until_idle(60, 1'b0, bad);
    n_tests++;
    if (en_cyc_q.size() != 8) begin
      n_fail++;
      $display("FAIL imiss_req_count: got %0d, required 8", en_cyc_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_tests++;
        if (en_cyc_q[i] != t0 + 1 + i || en_addr_q[i] !== 16'h1230 + 16'(2 * i)) begin
          n_fail++;
          $display("FAIL imiss_req%0d: got cycle %0d addr %h, required cycle %0d addr %h",
                   i, en_cyc_q[i] - t0, en_addr_q[i], 1 + i, 16'h1230 + 16'(2 * i));
        end
      end
    end
    n_tests++;
    if (word_cnt != 8 || exp_q.size() != 0 || last_word_cyc != t0 + 12) begin
      n_fail++;
      $display("FAIL imiss_words: got %0d words last at %0d, %0d left, required 8 at 12, 0 left",
               word_cnt, last_word_cyc - t0, exp_q.size());
    end
    n_tests++;
    if (tag_cnt != 1 || tag_cyc != t0 + 13) begin
      n_fail++;
      $display("FAIL imiss_tag_time: got %0d pulses at cycle %0d, required 1 at 13", tag_cnt, tag_cyc - t0);
    end
    n_tests++;
    if (tag_addr !== 16'h1230 || tag_tgt !== 1'b0) begin
      n_fail++;
      $display("FAIL imiss_tag_blk: got %h tgt %b, required 1230 tgt 0", tag_addr, tag_tgt);
    end
    n_tests++;
    if (last_busy_cyc != t0 + 13) begin
      n_fail++;
      $display("FAIL imiss_busy_fall: got falls at %0d, required 14", last_busy_cyc - t0 + 1);
    end
  endtask

  task automatic test_simultaneous();
    int t0, bad;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_log();
    bus.icache_miss_addr = 16'h0040;
    bus.dcache_miss_addr = 16'h8004;
    bus.icache_miss = 1'b1;
    bus.dcache_miss = 1'b1;
    t0 = cyc;
    push_block(1'b0, 16'h0040);
    push_block(1'b1, 16'h8000);
    snap_a_cyc = t0 + 5;
    snap_b_cyc = t0 + 20;
    run_until_idle(100, 1'b1, bad);
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL sim_dstall: got %0d cycles low while waiting, required 0", bad);
    end
    n_tests++;
    if (served_q.size() != 2 || served_q[0] !== 1'b0 || served_q[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL sim_order: got %0d fills first tgt %b, required 2 fills I then D",
               served_q.size(), (served_q.size() > 0) ? served_q[0] : 1'bx);
    end
    n_tests++;
    if (en_cyc_q.size() != 16 || en_cyc_q[8] != t0 + 15 || en_addr_q[8] !== 16'h8000) begin
      n_fail++;
      $display("FAIL sim_d_start: got %0d reqs, 9th at %0d addr %h, required 16, at 15 addr 8000",
               en_cyc_q.size(), (en_cyc_q.size() > 8) ? en_cyc_q[8] - t0 : -1,
               (en_addr_q.size() > 8) ? en_addr_q[8] : 16'hxxxx);
    end
    n_tests++;
    if (snap_a !== 4'b1110 || snap_b !== 4'b0111) begin
      n_fail++;
      $display("FAIL sim_stalls: got {istall,dstall,busy,tgt} %b/%b, required 1110/0111", snap_a, snap_b);
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sim_words: got %0d words missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_alternation();
    int bad;
    logic [15:0] ia[3] = '{16'hFFFE, 16'h0200, 16'h0410};
    logic [15:0] da[3] = '{16'h0000, 16'h0306, 16'h051A};
    bit di[3] = '{1'b0, 1'b1, 1'b1};
    logic exp_served[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    clear_log();
    for (int r = 0; r < 3; r++) begin
      bus.icache_miss_addr = ia[r];
      bus.dcache_miss_addr = da[r];
      bus.icache_miss = 1'b1;
      bus.dcache_miss = di[r];
      if (di[r]) push_block(1'b1, da[r] & 16'hFFF0);
      push_block(1'b0, ia[r] & 16'hFFF0);
      run_until_idle(100, 1'b1, bad);
    end
    n_tests++;
    if (served_q.size() != 5) begin
      n_fail++;
      $display("FAIL alt_count: got %0d fills, required 5", served_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_tests++;
        if (served_q[i] !== exp_served[i]) begin
          n_fail++;
          $display("FAIL alt_order%0d: got tgt %b, required %b", i, served_q[i], exp_served[i]);
        end
      end
    end
    n_tests++;
    if (en_addr_q.size() < 8 || en_addr_q[7] !== 16'hFFFE) begin
      n_fail++;
      $display("FAIL alt_top_addr: got %h, required FFFE",
               (en_addr_q.size() >= 8) ? en_addr_q[7] : 16'hxxxx);
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL alt_words: got %0d words missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_bursty();
    int bad;
    clear_log();
    gap_mode = 1'b1;
    bus.dcache_miss_addr = 16'h4A5E;
    bus.dcache_miss = 1'b1;
    push_block(1'b1, 16'h4A50);
    run_until_idle(200, 1'b1, bad);
    gap_mode = 1'b0;
    n_tests++;
    if (word_cnt != 8 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL burst_words: got %0d words, %0d missing, required 8, 0", word_cnt, exp_q.size());
    end
    n_tests++;
    if (tag_cnt != 1 || tag_cyc != last_word_cyc + 1) begin
      n_fail++;
      $display("FAIL burst_tag: got %0d pulses %0d cycles after last word, required 1, 1",
               tag_cnt, tag_cyc - last_word_cyc);
    end
  endtask

  task automatic test_reset_mid_fill();
    int n;
    clear_log();
    bus.dcache_miss_addr = 16'h7777;
    bus.dcache_miss = 1'b1;
    push_block(1'b1, 16'h7770);
    n = 0;
    while (word_cnt < 3 && n < 40) begin
      tick();
      n++;
    end
    n_tests++;
    if (word_cnt != 3) begin
      n_fail++;
      $display("FAIL rst_wait: got %0d words, required 3", word_cnt);
    end
    rst = 1'b1;
    bus.dcache_miss = 1'b0;
    tick();
    n_tests++;
    if ({dbg_state, bus.busy, bus.mem_enable, bus.fill_word_en, bus.fill_tag_write,
         bus.icache_stall, bus.dcache_stall, bus.fill_target} !== 9'b0 ||
        bus.mem_addr !== 16'h0 || bus.fill_block_addr !== 16'h0) begin
      n_fail++;
      $display("FAIL rst_outputs: got flags %b mem_addr %h blk %h, required all 0",
               {dbg_state, bus.busy, bus.mem_enable, bus.fill_word_en, bus.fill_tag_write,
                bus.icache_stall, bus.dcache_stall, bus.fill_target}, bus.mem_addr, bus.fill_block_addr);
    end
    rst = 1'b0;
    exp_q.delete();
    repeat (20) tick();
    n_tests++;
    if (word_cnt != 3 || tag_cnt != 0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_after: got %0d words %0d tags busy %b, required 3 0 0", word_cnt, tag_cnt, bus.busy);
    end
  endtask

  task automatic test_stray_and_drop();
    int bad, n_en;
    clear_log();
    stray_mode = 1'b1;
    repeat (4) tick();
    stray_mode = 1'b0;
    n_tests++;
    if (word_cnt != 0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stray_idle: got %0d words busy %b, required 0 0", word_cnt, bus.busy);
    end
    bus.icache_miss_addr = 16'h0A2C;
    bus.icache_miss = 1'b1;
    push_block(1'b0, 16'h0A20);
    run_until_idle(60, 1'b0, bad);
    n_en = en_cyc_q.size();
    repeat (6) tick();
    n_tests++;
    if (en_cyc_q.size() != 8 || n_en != 8 || tag_cnt != 1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_in_done: got %0d reqs %0d tags busy %b, required 8 1 0",
               en_cyc_q.size(), tag_cnt, bus.busy);
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drop_words: got %0d words missing, required 0", exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.icache_miss = 1'b0;
    bus.icache_miss_addr = 16'h0000;
    bus.dcache_miss = 1'b0;
    bus.dcache_miss_addr = 16'h0000;
    test_reset();
    test_single_imiss();
    test_simultaneous();
    test_alternation();
    test_bursty();
    test_reset_mid_fill();
    test_stray_and_drop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cache_fill_ctrl.md
Name: cache_fill_ctrl

Overview:
Miss-handling controller for the 2-way, 64-set, 16B-block caches. It arbitrates between I-cache and D-cache read misses and owns the single shared main-memory read port. For the winning cache it streams the 8-word block into the cache DataArray, then pulses the MetaDataArray tag/valid write. Stores are write-through and handled elsewhere, so this block issues memory reads only.

Parameters:
WORDS_PER_BLOCK, 8, words per 16B block; sizes the 3-bit word offset and the 4-bit issue/receive counters.
MEM_LATENCY, 4, memory read latency in cycles. Informational and used by the bench model only; the controller relies solely on mem_data_valid.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
icache_miss  in  1  I-cache miss; held high until the block is filled
icache_miss_addr  in  16  byte address of the I-cache miss
dcache_miss  in  1  D-cache miss; held high until the block is filled
dcache_miss_addr  in  16  byte address of the D-cache miss
mem_data_valid  in  1  memory returns one word this cycle
mem_data_in  in  16  returned memory word
mem_enable  out  1  read request valid this cycle
mem_addr  out  16  read word address (byte address, bit 0 = 0)
fill_target  out  1  0 = I-cache, 1 = D-cache
fill_word_en  out  1  write fill_data into the target DataArray word
fill_word_offset  out  3  word within the block (address bits [3:1])
fill_data  out  16  equal to mem_data_in
fill_block_addr  out  16  block base address being filled (bits [3:0] = 0)
fill_tag_write  out  1  one-cycle pulse: write tag and set valid in the target MetaDataArray
icache_stall  out  1  stall the fetch stage
dcache_stall  out  1  stall the memory stage
busy  out  1  high whenever state is not IDLE

Behaviour:
- States: IDLE, FILL, DONE. Reset puts the FSM in IDLE, clears both counters, sets last_served = D, and drives every registered output to 0.
- IDLE:
  - If a single miss is pending, that cache wins.
  - If both are pending, the cache not equal to last_served wins. After reset, a simultaneous miss therefore serves I first.
  - On a win: latch base = addr & 16'hFFF0, latch fill_target, update last_served, go to FILL.
  - With no miss pending, stay in IDLE.
- FILL, issue side:
  - While issue_cnt < 8: mem_enable = 1, mem_addr = base + 2*issue_cnt, issue_cnt++.
  - Addresses go out on 8 consecutive cycles; memory accepts one per cycle.
- FILL, receive side:
  - When mem_data_valid is high and recv_cnt < 8: fill_word_en = 1, fill_word_offset = recv_cnt[2:0], fill_data = mem_data_in (combinational pass-through), recv_cnt++.
  - Words are written in issue order, offset 0 through 7.
- FILL exit: when recv_cnt reaches 8, go to DONE.
- DONE: fill_tag_write = 1 for exactly one cycle with fill_block_addr and fill_target held, then go to IDLE. Both counters clear on entering IDLE.
- Outputs while not in FILL/DONE: fill_block_addr and fill_target hold their latched values; fill_word_en and fill_tag_write are 0.
- Stalls:
  - icache_stall = icache_miss | (busy & fill_target==0).
  - dcache_stall = dcache_miss | (busy & fill_target==1).
  - The losing requester keeps stalling until it is served.
- Latency: miss seen in IDLE at cycle 0 → addresses at cycles 1–8 → data at cycles 1+L through 8+L → DONE at cycle 9+L → IDLE at 10+L. With L = 4, DONE is at cycle 13.
- Ignored inputs:
  - mem_data_valid outside FILL, or when recv_cnt = 8.
  - Miss inputs outside IDLE. A second miss is taken in the first IDLE cycle in which it is still asserted.
- Reset mid-fill: return to IDLE immediately. No fill_tag_write is issued and in-flight memory returns are ignored. The partially written block stays invalid because its tag was never written.
- Miss-address changes while not in IDLE have no effect on the latched base.

Test Plan:
- Single I-miss at addr 16'h1236, memory L = 4 → mem_addr 16'h1230 through 16'h123E on cycles 1–8; offsets 0–7 written with the model's data; fill_tag_write pulses at cycle 13 with fill_block_addr 16'h1230 and fill_target 0; busy falls at cycle 14.
- I-miss and D-miss raised together after reset (I 16'h0040, D 16'h8004) → I block 16'h0040 filled first; dcache_stall stays high throughout; D block 16'h8000 starts in the first IDLE cycle afterwards.
- Repeated simultaneous misses → served targets alternate I, D, I, D; no cache is starved.
- Bursty memory with mem_data_valid gaps of 2 cycles → still exactly 8 fill_word_en pulses in offset order 0–7; exactly one fill_tag_write after the 8th word.
- rst asserted for one cycle after the 3rd word of a D fill → IDLE next cycle; no fill_tag_write; late mem_data_valid produces no fill_word_en; all outputs 0.
- Stray mem_data_valid in IDLE, plus a miss that drops while the FSM is in DONE → no fill_word_en, and no new fill starts.
